// File: rtl/rv_core_pkg.sv
// Shared core definitions: instruction width, canonical NOP and the fetch
// response payload carried by the fetch buffer and the IF/ID register.
package rv_core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] addr;
      logic            fault;
   } fetch_resp_t;

endpackage

// File: rtl/instr_resp_fifo.sv
// Fetch response FIFO: head-visible storage with push/pop, flush and occupancy.
module instr_resp_fifo
   import rv_core_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  fetch_resp_t                i_push_data,
   input  logic                       i_pop,
   output fetch_resp_t                o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_resp_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_pop = i_pop & (r_count != '0);

   // Pointers wrap modulo DEPTH; flush empties the queue in one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory: registered-read array, fault detection,
// credit-limited response buffering with flush and a program-loader port.
module instr_mem_pipe
   import rv_core_pkg::*;
#(
   parameter int unsigned       DATA_W    = XLEN,
   parameter int unsigned       DEPTH     = 1024,
   parameter int unsigned       LATENCY   = 1,
   parameter int unsigned       BUF_DEPTH = 2,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(RV_NOP)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_W-1:0]        resp_data,
   output logic [31:0]              resp_addr,
   output logic                     resp_fault,
   input  logic                     flush,
   input  logic                     ld_en,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [DATA_W-1:0]        ld_data
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 2;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_s1_valid;
   logic              r_s1_fault;
   logic [31:0]       r_s1_addr;

   logic              w_accept;
   logic              w_fault;
   logic [AW-1:0]     w_idx;
   fetch_resp_t       w_s1_resp;
   fetch_resp_t       w_fin_resp;
   logic              w_fin_valid;
   logic              w_s2_valid;
   fetch_resp_t       w_head;
   fetch_resp_t       w_out;
   logic [CNT_W-1:0]  w_count;
   logic              w_fifo_empty;
   logic              w_out_valid;
   logic              w_push;
   logic              w_pop;
   logic [SUM_W-1:0]  w_total;

   assign w_idx    = req_addr[2 +: AW];
   assign w_fault  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
   assign w_accept = req_valid & req_ready;

   // Every accepted fetch holds one credit until it leaves the buffer.
   assign w_total   = SUM_W'(r_s1_valid) + SUM_W'(w_s2_valid) + SUM_W'(w_count);
   assign req_ready = rst & ~ld_en & (w_total < SUM_W'(BUF_DEPTH));

   // Array port: read-before-write on address collision; faulted fetches skip the read.
   always_ff @(posedge clk) begin
      if (ld_en) r_mem[ld_addr] <= ld_data;
      if (w_accept && !w_fault) r_rd_data <= r_mem[w_idx];
   end

   // A request accepted alongside a flush is the redirect target and survives.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_fault <= 1'b0;
         r_s1_addr  <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_fault <= w_fault;
            r_s1_addr  <= req_addr;
         end
      end
   end

   assign w_s1_resp = '{data:  r_s1_fault ? XLEN'(NOP_INSTR) : XLEN'(r_rd_data),
                        addr:  r_s1_addr,
                        fault: r_s1_fault};

   if (LATENCY == 2) begin : g_lat2
      logic        r_s2_valid;
      fetch_resp_t r_s2_resp;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_resp  <= '0;
         end else begin
            r_s2_valid <= r_s1_valid & ~flush;
            if (r_s1_valid) r_s2_resp <= w_s1_resp;
         end
      end

      assign w_s2_valid  = r_s2_valid;
      assign w_fin_valid = r_s2_valid;
      assign w_fin_resp  = r_s2_resp;
   end else begin : g_lat1
      assign w_s2_valid  = 1'b0;
      assign w_fin_valid = r_s1_valid;
      assign w_fin_resp  = w_s1_resp;
   end

   // Empty buffer: the final stage is presented directly so latency stays LATENCY.
   assign w_out_valid = ~w_fifo_empty | w_fin_valid;
   assign w_out       = w_fifo_empty ? w_fin_resp : w_head;
   assign w_pop       = w_out_valid & resp_ready & ~w_fifo_empty;
   assign w_push      = w_fin_valid & ~flush & ~(w_fifo_empty & resp_ready);

   instr_resp_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_flush     (flush),
      .i_push      (w_push),
      .i_push_data (w_fin_resp),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_empty     (w_fifo_empty)
   );

   assign resp_valid = w_out_valid;
   assign resp_data  = w_out_valid ? DATA_W'(w_out.data) : '0;
   assign resp_addr  = w_out_valid ? w_out.addr : '0;
   assign resp_fault = w_out_valid & w_out.fault;

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Scenario bench for instr_mem_pipe against a queue-based cycle model.
module tb_instr_mem_pipe;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned LATENCY   = 2;
   localparam int unsigned BUF_DEPTH = 4;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic        clk, rst, req_valid, req_ready, resp_valid, resp_ready;
   logic [31:0] req_addr, resp_addr;
   logic [31:0] resp_data;
   logic        resp_fault, flush, ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   instr_mem_pipe #(
      .DATA_W (DATA_W), .DEPTH (DEPTH), .LATENCY (LATENCY),
      .BUF_DEPTH (BUF_DEPTH), .NOP_INSTR (NOP)
   ) dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready), .req_addr (req_addr),
      .resp_valid (resp_valid), .resp_ready (resp_ready), .resp_data (resp_data),
      .resp_addr (resp_addr), .resp_fault (resp_fault),
      .flush (flush), .ld_en (ld_en), .ld_addr (ld_addr), .ld_data (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      logic        fault;
      int          due;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mm [DEPTH];
   logic [31:0] prog [4];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;

   // Model: each accepted fetch becomes visible LATENCY cycles later, in order.
   function automatic bit model_valid();
      return (q.size() > 0) && (q[0].due <= cyc);
   endfunction

   function automatic bit model_ready();
      return rst && !ld_en && (q.size() < int'(BUF_DEPTH));
   endfunction

   function automatic logic [66:0] model_vec();
      if (model_valid()) return {model_ready(), 1'b1, q[0].fault, q[0].addr, q[0].data};
      return {model_ready(), 1'b0, 65'd0};
   endfunction

   function automatic logic [66:0] dut_vec();
      if (model_valid()) return {req_ready, resp_valid, resp_fault, resp_addr, resp_data};
      return {req_ready, resp_valid, 65'd0};
   endfunction

   // Applies the handshakes of the current cycle to the model, then advances a clock.
   task automatic model_step();
      bit   pop, acc;
      exp_t e;
      pop = model_valid() && resp_ready;
      acc = req_valid && model_ready();
      checks++;
      if (int'(dut.u_fifo.o_count) > int'(BUF_DEPTH)) begin
         errors++;
         $display("FAIL overflow cyc=%0d count=%0d limit=%0d", cyc, dut.u_fifo.o_count, BUF_DEPTH);
      end
      if (pop) void'(q.pop_front());
      if (flush || !rst) q.delete();
      if (acc) begin
         e.addr  = req_addr;
         e.fault = (req_addr % 4 != 0) || ((req_addr / 4) >= DEPTH);
         e.data  = e.fault ? NOP : mm[int'(req_addr / 4)];
         e.due   = cyc + int'(LATENCY);
         q.push_back(e);
      end
      if (ld_en) mm[int'(ld_addr)] = ld_data;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
      flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({req_ready, resp_valid, resp_fault} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=000", {req_ready, resp_valid, resp_fault});
      end
      checks++;
      if ({resp_data, resp_addr} !== 64'd0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h want=0/0", resp_data, resp_addr);
      end
      model_step();
      model_step();
      rst = 1'b1;
   endtask

   task automatic test_load();
      for (int i = 0; i < 17; i++) begin
         ld_en   = 1'b1;
         ld_addr = (i == 16) ? 10'(DEPTH - 1) : 10'(i);
         ld_data = (i < 4) ? prog[i] : $urandom;
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL load cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         model_step();
      end
      ld_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n_resp = 0;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_valid = (i < 4);
         req_addr  = 32'(i * 4);
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL b2b cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         if (i >= int'(LATENCY) && i < 4 + int'(LATENCY)) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_addr !== 32'((i - int'(LATENCY)) * 4) ||
                resp_data !== prog[i - int'(LATENCY)] || resp_fault !== 1'b0) begin
               errors++;
               $display("FAIL b2b_latency i=%0d got v=%b a=%h d=%h want a=%h d=%h", i,
                        resp_valid, resp_addr, resp_data, (i - int'(LATENCY)) * 4, prog[i - int'(LATENCY)]);
            end
         end
         if (resp_valid) n_resp++;
         model_step();
      end
      req_valid = 1'b0;
      checks++;
      if (n_resp != 4) begin
         errors++;
         $display("FAIL b2b_count got=%0d want=4", n_resp);
      end
   endtask

   task automatic test_backpressure();
      int          acc = 0;
      logic [31:0] hold_addr = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'($urandom_range(0, 15) * 4);
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL stall cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         if (i == int'(LATENCY)) hold_addr = resp_addr;
         if (req_valid && req_ready) acc++;
         model_step();
      end
      checks++;
      if (acc != int'(BUF_DEPTH) || resp_addr !== hold_addr) begin
         errors++;
         $display("FAIL stall_credit accepted=%0d want=%0d head=%h want=%h", acc, BUF_DEPTH, resp_addr, hold_addr);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL drain cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         model_step();
      end
   endtask

   task automatic test_fault();
      logic [31:0] faddr [5];
      logic        ffault [5];
      faddr  = '{32'h6, 32'h1000, 32'hFFC, 32'hFFFF_FFFC, 32'h1};
      ffault = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         req_valid = (i < 5);
         req_addr  = (i < 5) ? faddr[i] : '0;
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL fault cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         if (i >= int'(LATENCY) && i < 5 + int'(LATENCY)) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_addr !== faddr[i - int'(LATENCY)] ||
                resp_fault !== ffault[i - int'(LATENCY)] ||
                (ffault[i - int'(LATENCY)] && resp_data !== NOP)) begin
               errors++;
               $display("FAIL fault_resp i=%0d got v=%b a=%h f=%b d=%h want a=%h f=%b", i,
                        resp_valid, resp_addr, resp_fault, resp_data,
                        faddr[i - int'(LATENCY)], ffault[i - int'(LATENCY)]);
            end
         end
         model_step();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_flush();
      int n_valid = 0;
      bit seen    = 0;
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'(i * 4);
         flush     = (i == 2);
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL flush cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         model_step();
      end
      flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL flush_drain cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         if (resp_valid) begin
            n_valid++;
            if (!seen) begin
               seen = 1;
               checks++;
               if (resp_addr !== 32'h8 || resp_data !== prog[2] || resp_fault !== 1'b0) begin
                  errors++;
                  $display("FAIL flush_target got a=%h d=%h want a=00000008 d=%h", resp_addr, resp_data, prog[2]);
               end
            end
         end
         model_step();
      end
      checks++;
      if (!seen || n_valid != 1) begin
         errors++;
         $display("FAIL flush_count responses=%0d want=1", n_valid);
      end
   endtask

   task automatic test_load_during_fetch();
      logic [31:0] want;
      resp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1;
         req_addr  = (i == 0) ? 32'hC : 32'h0;
         ld_en     = (i == 1);
         ld_addr   = 10'd3;
         ld_data   = 32'hDEAD_BEEF;
         @(negedge clk);
         if (i == 1) begin
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL load_ready got=%b want=0", req_ready);
            end
         end
         model_step();
      end
      ld_en = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         bit seen = 0;
         want = (pass == 0) ? prog[3] : 32'hDEAD_BEEF;
         for (int i = 0; i < 10 && !seen; i++) begin
            req_valid = (pass == 1 && i == 0);
            req_addr  = 32'hC;
            @(negedge clk);
            checks++;
            if (dut_vec() !== model_vec()) begin
               errors++;
               $display("FAIL load_fetch cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
            end
            if (resp_valid) begin
               seen = 1;
               checks++;
               if (resp_addr !== 32'hC || resp_data !== want) begin
                  errors++;
                  $display("FAIL load_data pass=%0d got a=%h d=%h want a=0000000c d=%h", pass, resp_addr, resp_data, want);
               end
            end
            model_step();
         end
         req_valid = 1'b0;
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL load_timeout pass=%0d no response", pass);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         int sel;
         sel        = int'($urandom_range(0, 9));
         req_valid  = ($urandom_range(0, 3) != 0);
         req_addr   = (sel < 7)  ? 32'($urandom_range(0, 15) * 4) :
                      (sel == 7) ? 32'((DEPTH - 1) * 4) :
                      (sel == 8) ? 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3)) :
                                   32'(DEPTH * 4 + $urandom_range(0, 4095) * 4);
         resp_ready = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         ld_en      = ($urandom_range(0, 19) == 0);
         ld_addr    = 10'($urandom_range(0, 15));
         ld_data    = $urandom;
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         model_step();
      end
      idle_inputs();
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random_drain cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         model_step();
      end
   endtask

   task automatic test_reset_mid();
      int n_valid = 0;
      bit seen    = 0;
      resp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_addr  = 32'h4;
         @(negedge clk);
         model_step();
      end
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({resp_valid, req_ready} !== 2'b00 || resp_data !== 32'd0 || resp_addr !== 32'd0) begin
         errors++;
         $display("FAIL reset_async got v=%b r=%b d=%h a=%h want 0", resp_valid, req_ready, resp_data, resp_addr);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         model_step();
      end
      rst = 1'b1;
      resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_valid = (i == 0);
         req_addr  = 32'h8;
         @(negedge clk);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL post_reset cyc=%0d dut=%h model=%h", cyc, dut_vec(), model_vec());
         end
         if (resp_valid) begin
            n_valid++;
            if (!seen) begin
               seen = 1;
               checks++;
               if (resp_addr !== 32'h8) begin
                  errors++;
                  $display("FAIL post_reset_first got a=%h want a=00000008", resp_addr);
               end
            end
         end
         model_step();
      end
      req_valid = 1'b0;
      checks++;
      if (n_valid != 1) begin
         errors++;
         $display("FAIL post_reset_count responses=%0d want=1", n_valid);
      end
   endtask

   initial begin
      prog = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_006F};
      idle_inputs();
      rst = 1'b1;
      #1 rst = 1'b0;
      test_reset();
      test_load();
      test_back_to_back();
      test_backpressure();
      test_fault();
      test_flush();
      test_load_during_fetch();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
Parametrised, synchronous instruction memory for the pipelined RISC-V core. It succeeds the combinational fetch ROM.
- Fetch side: valid/ready request and response channels, configurable read latency, credit-limited response buffering.
- Control: flush for redirects, address fault detection.
- Loader: write port for program loading, in place of a file preload.
Sits between the IF-stage PC logic and the IF/ID register.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 1024, number of instruction words (power of two)
LATENCY, 1, array read pipeline stages, legal values 1 or 2
BUF_DEPTH, 2, response buffer entries (>= LATENCY)
NOP_INSTR, 32'h00000013, word returned on faulted fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  32  byte address of instruction
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_data  out  DATA_W  fetched instruction
resp_addr  out  32  byte address of the returned instruction
resp_fault  out  1  misaligned or out-of-range fetch
flush  in  1  discard all in-flight and buffered fetches
ld_en  in  1  loader write enable
ld_addr  in  $clog2(DEPTH)  loader word index
ld_data  in  DATA_W  loader write data

Behaviour:
- Reset (rst=0, async):
  - All pipeline valid bits, buffer pointers and the occupancy count clear.
  - Outputs: req_ready=0 while rst=0; resp_valid=0, resp_data=0, resp_addr=0, resp_fault=0.
  - Array contents are not reset.
  - Reset mid-fetch drops everything; no response ever emerges for pre-reset requests.
- Word index = req_addr[2+$clog2(DEPTH)-1:2].
- Fault = (req_addr[1:0]!=0) or (req_addr[31:2] >= DEPTH).
  - A faulted fetch does not read the array.
  - It returns resp_data=NOP_INSTR, resp_fault=1, resp_addr=req_addr.
- Latency: a request accepted in cycle N presents resp_valid in cycle N+LATENCY if the buffer is empty, independent of resp_ready.
- Ordering: responses return strictly in request order.
- Credit rule: req_ready = rst & !ld_en & (inflight + buffered < BUF_DEPTH).
  - Counting uses the current-cycle values of inflight and buffered.
  - A same-cycle pop does not grant a credit until the next cycle (no combinational path resp_ready->req_ready).
- Response buffer: BUF_DEPTH-entry FIFO.
  - Head drives resp_*.
  - Push when a pipeline stage completes; pop on resp_valid&resp_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Overflow is impossible by the credit rule; the bench asserts this.
- resp_* hold stable while resp_valid=1 and resp_ready=0.
- Flush:
  - In the flush cycle, all pipeline stage valids and all buffer entries are invalidated; the count returns to 0.
  - resp_valid goes low next cycle.
  - A request accepted in the same cycle as flush is kept: it is the redirect target.
  - A response popped in the flush cycle counts as consumed.
- Loader:
  - ld_en=1 writes mem[ld_addr] <= ld_data at the clock edge.
  - req_ready=0 while ld_en=1; in-flight fetches still drain.
  - A read of the same word in the same cycle as a write returns the old data (read-before-write).
- Wrap-around: buffer pointers are modulo BUF_DEPTH; the count width is $clog2(BUF_DEPTH+1).
- The array is inferrable as BRAM: registered read, and with LATENCY=2 an extra output register.

Decomposition:
- Shared package rv_core_pkg holds:
  - NOP_INSTR (RV_NOP)
  - the instruction width constant XLEN=32
  - a typedef fetch_resp_t {data, addr, fault} used by the buffer and the IF/ID register.
- One sub-module: instr_resp_fifo, a parametrised synchronous FIFO of fetch_resp_t with flush, push, pop, count and head outputs.
- Array, fault logic and latency pipeline stay in instr_mem_pipe.

Test Plan:
- Load words 0..3 with 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F, then issue back-to-back fetches 0x0,0x4,0x8,0xC with resp_ready=1 -> responses in order, each LATENCY cycles after acceptance, fault=0, one per cycle.
- Hold resp_ready=0 and issue fetches -> exactly BUF_DEPTH accepted, req_ready=0 thereafter; release -> buffered data drains in order, stable while stalled.
- Fetch 0x6 and 0x1000 (DEPTH=1024) -> resp_data=0x00000013, resp_fault=1, resp_addr echoed.
- Two fetches in flight, then flush together with a request to 0x8 -> the two old responses are never presented; the next response is word 2, addr 0x8.
- Assert ld_en during an outstanding fetch -> req_ready=0 while loading; the in-flight response is delivered; a same-cycle read of the written word returns the old value.
- Drop rst mid-stream with the buffer full -> resp_valid=0 immediately (async); after release, the first response corresponds only to a post-reset request.
